// File: rtl/adc_pkg.sv
// adc_pkg: shared types and elaboration helpers for the multi-channel ADC reader.
// The ADC_TEST_PATTERN_EN macro selects the test-pattern data source in adc_multi_read.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SHIFT,
        WAIT
    } adc_state_e;

    // Width of a down-counter that has to hold values 0 .. n-1. The result is never below 1 bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // The frame must fit the conversion, the full SCK burst, the commit cycle and one spare cycle.
    function automatic bit frame_len_ok(input int conv_cyc, input int sck_div,
                                        input int data_w, input int frame_cyc);
        return (sck_div >= 1) && (conv_cyc >= 1) && (data_w >= 2) &&
               (frame_cyc >= conv_cyc + 2 * sck_div * data_w + 2);
    endfunction

endpackage

// File: rtl/adc_shift_lane.sv
// adc_shift_lane: one MISO lane. It is a DATA_W-bit shift register that takes the MSB first.
module adc_shift_lane #(
    parameter int DATA_W = 16
) (
    input  logic              clk_adc,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic              bit_i,
    output logic [DATA_W-1:0] word_o
);

    // Shift the lane bit in at the LSB on every SCK rising edge. After DATA_W shifts the first bit sits in the MSB.
    always_ff @(posedge clk_adc) begin
        if (!rst_n) begin
            word_o <= '0;
        end else if (shift_en) begin
            word_o <= {word_o[DATA_W-2:0], bit_i};
        end
    end

endmodule

// File: rtl/adc_multi_read.sv
// adc_multi_read: starts a conversion on N_CH parallel serial ADCs and clocks the results out of them.
// It presents one committed word per channel through a valid/ready register.
// Optional build macro ADC_TEST_PATTERN_EN: when it is defined, each committed word is
// (frame count after the commit + channel index) and the MISO lanes are ignored.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | pins idle (CNV high, SCK low) and wait for enable_i
// CONV  | CNV held low for CONV_CYC cycles while the ADCs convert
// SHIFT | DATA_W SCK periods, with every lane sampling on SCK rising edges
// WAIT  | frame commits on the first cycle, then pad out to FRAME_CYC
module adc_multi_read
    import adc_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int N_CH      = 4,
    parameter int SCK_DIV   = 2,
    parameter int CONV_CYC  = 40,
    parameter int FRAME_CYC = 200
) (
    input  logic                   clk_adc,
    input  logic                   rst_n,
    input  logic                   enable_i,
    input  logic [N_CH-1:0]        adc_miso_i,
    output logic                   adc_sck_o,
    output logic                   adc_cnv_n_o,
    output logic [N_CH*DATA_W-1:0] data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   overrun_o,
    output logic [15:0]            frame_cnt_o
);

    localparam int CONV_W = cnt_w(CONV_CYC);
    localparam int DIV_W  = cnt_w(SCK_DIV);
    localparam int BIT_W  = cnt_w(DATA_W);
    localparam int FRM_W  = cnt_w(FRAME_CYC);

    if (!frame_len_ok(CONV_CYC, SCK_DIV, DATA_W, FRAME_CYC)) begin : g_bad_cfg
        $error("adc_multi_read: FRAME_CYC must be at least CONV_CYC + 2*SCK_DIV*DATA_W + 2");
    end

    adc_state_e             state;
    logic [CONV_W-1:0]      conv_cnt;
    logic [DIV_W-1:0]       div_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [FRM_W-1:0]       frame_tmr;
    logic                   sck_q;
    logic                   cnv_n_q;
    logic                   commit_q;
    logic                   shift_en;
    logic [N_CH*DATA_W-1:0] frame_word;
    logic [N_CH*DATA_W-1:0] data_q;
    logic                   valid_q;
    logic                   overrun_q;
    logic [15:0]            frame_cnt_q;

    // Lanes sample on the clk edge that drives SCK from 0 to 1.
    assign shift_en = (state == SHIFT) && (div_cnt == '0) && !sck_q;

    // Frame sequencer. The frame timer counts down from FRAME_CYC-1, so the frame period is fixed
    // no matter how long SHIFT takes. commit_q is high for exactly the first WAIT cycle.
    always_ff @(posedge clk_adc) begin
        if (!rst_n) begin
            state     <= IDLE;
            conv_cnt  <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            frame_tmr <= '0;
            sck_q     <= 1'b0;
            cnv_n_q   <= 1'b1;
            commit_q  <= 1'b0;
        end else begin
            commit_q <= 1'b0;
            if (frame_tmr != '0) begin
                frame_tmr <= frame_tmr - FRM_W'(1);
            end
            unique case (state)
                IDLE: begin
                    if (enable_i) begin
                        state     <= CONV;
                        cnv_n_q   <= 1'b0;
                        conv_cnt  <= CONV_W'(CONV_CYC - 1);
                        frame_tmr <= FRM_W'(FRAME_CYC - 1);
                    end
                end
                CONV: begin
                    if (conv_cnt == '0) begin
                        state   <= SHIFT;
                        cnv_n_q <= 1'b1;
                        div_cnt <= DIV_W'(SCK_DIV - 1);
                        bit_cnt <= BIT_W'(DATA_W - 1);
                    end else begin
                        conv_cnt <= conv_cnt - CONV_W'(1);
                    end
                end
                SHIFT: begin
                    if (div_cnt == '0) begin
                        div_cnt <= DIV_W'(SCK_DIV - 1);
                        sck_q   <= !sck_q;
                        if (sck_q) begin
                            if (bit_cnt == '0) begin
                                state    <= WAIT;
                                commit_q <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt - BIT_W'(1);
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end
                end
                WAIT: begin
                    if (frame_tmr == '0) begin
                        if (enable_i) begin
                            state     <= CONV;
                            cnv_n_q   <= 1'b0;
                            conv_cnt  <= CONV_W'(CONV_CYC - 1);
                            frame_tmr <= FRM_W'(FRAME_CYC - 1);
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADC_TEST_PATTERN_EN
    logic [15:0] cnt_next;

    assign cnt_next = frame_cnt_q + 16'd1;

    // Test pattern: each channel word is the post-commit frame count offset by the channel index.
    always_comb begin
        frame_word = '0;
        for (int k = 0; k < N_CH; k++) begin
            frame_word[k*DATA_W +: DATA_W] = DATA_W'(cnt_next) + DATA_W'(k);
        end
    end
`else
    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        adc_shift_lane #(
            .DATA_W(DATA_W)
        ) u_lane (
            .clk_adc  (clk_adc),
            .rst_n    (rst_n),
            .shift_en (shift_en),
            .bit_i    (adc_miso_i[k]),
            .word_o   (frame_word[k*DATA_W +: DATA_W])
        );
    end
`endif

    // Output register. A commit that finds an unconsumed word drops the new frame and sets the sticky overrun.
    // A commit in the same cycle as a transfer loads the new frame.
    always_ff @(posedge clk_adc) begin
        if (!rst_n) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else if (commit_q) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            if (valid_q && !ready_i) begin
                overrun_q <= 1'b1;
            end else begin
                data_q  <= frame_word;
                valid_q <= 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign adc_sck_o   = sck_q;
    assign adc_cnv_n_o = cnv_n_q;
    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign overrun_o   = overrun_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule
